// File: rtl/mux_scan_ctrl_if.sv
// Bundle of scan controls and display-drive outputs between the host and the scan sequencer.
// The master drives the controls; the slave (the sequencer) drives the select and enables.
interface mux_scan_ctrl_if #(
  parameter int unsigned DWELL_W = 16
);
  logic               En;
  logic               Sync;
  logic [DWELL_W-1:0] Dwell;
  logic [3:0]         Mask;
  logic [1:0]         S;
  logic [3:0]         Dig;
  logic               Blank;
  logic               FrameDone;

  modport master (
    output En, Sync, Dwell, Mask,
    input  S, Dig, Blank, FrameDone
  );

  modport slave (
    input  En, Sync, Dwell, Mask,
    output S, Dig, Blank, FrameDone
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Display scan sequencer: walks the mux select over unmasked digits with a
// programmable dwell, a fixed blanking gap between digits and a wrap marker.
module mux_scan_ctrl #(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned BLANK   = 4
) (
  input logic            Clk,
  input logic            Reset,
  mux_scan_ctrl_if.slave bus
);

  localparam int unsigned GAP_W    = 8;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BLANK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         s_q, s_d;
  logic [3:0]         dig_q, dig_d;
  logic               blank_q, blank_d;
  logic               frame_done_q, frame_done_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0] dwell_len_q, dwell_len_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               restart_q, restart_d;

  logic [2:0]         first_c;
  logic [2:0]         after_c;
  logic [2:0]         sel_c;
  logic [DWELL_W-1:0] eff_dwell_c;

  // Returns {found, index}: first unmasked position at start, start+1, ... modulo 4.
  function automatic logic [2:0] find_unmasked(input logic [1:0] start, input logic [3:0] mask);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (!mask[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    frame_done_d = 1'b0;
    dwell_cnt_d  = dwell_cnt_q;
    dwell_len_d  = dwell_len_q;
    gap_cnt_d    = gap_cnt_q;
    restart_d    = restart_q;
    sel_c        = 3'b000;

    first_c     = find_unmasked(2'd0, bus.Mask);
    after_c     = find_unmasked(s_q + 2'd1, bus.Mask);
    eff_dwell_c = (bus.Dwell == '0) ? DWELL_W'(1) : bus.Dwell;

    if (!bus.En) begin
      state_d     = ST_IDLE;
      dwell_cnt_d = '0;
      gap_cnt_d   = '0;
      restart_d   = 1'b0;
    end else if (bus.Sync) begin
      // Restart marker: the following selection starts over from position 0 without a wrap pulse.
      state_d     = ST_GAP;
      dwell_cnt_d = '0;
      gap_cnt_d   = '0;
      restart_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (first_c[2]) begin
            state_d     = ST_SHOW;
            s_d         = first_c[1:0];
            dwell_cnt_d = '0;
            dwell_len_d = eff_dwell_c;
          end
        end
        ST_SHOW: begin
          if (dwell_cnt_q == dwell_len_q - DWELL_W'(1)) begin
            state_d     = ST_GAP;
            dwell_cnt_d = '0;
            gap_cnt_d   = '0;
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            sel_c     = restart_q ? first_c : after_c;
            restart_d = 1'b0;
            gap_cnt_d = '0;
            if (!sel_c[2]) begin
              state_d = ST_IDLE;
            end else begin
              state_d      = ST_SHOW;
              s_d          = sel_c[1:0];
              dwell_cnt_d  = '0;
              dwell_len_d  = eff_dwell_c;
              frame_done_d = !restart_q && (sel_c[1:0] <= s_q);
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Display drive is derived from the next state so it lines up with the registered select.
    dig_d   = (state_d == ST_SHOW) ? (4'b0001 << s_d) : 4'b0000;
    blank_d = (state_d != ST_SHOW);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      s_q          <= 2'b00;
      dig_q        <= 4'b0000;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
      dwell_cnt_q  <= '0;
      dwell_len_q  <= DWELL_W'(1);
      gap_cnt_q    <= '0;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      dig_q        <= dig_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
      dwell_cnt_q  <= dwell_cnt_d;
      dwell_len_q  <= dwell_len_d;
      gap_cnt_q    <= gap_cnt_d;
      restart_q    <= restart_d;
    end
  end

  assign bus.S         = s_q;
  assign bus.Dig       = dig_q;
  assign bus.Blank     = blank_q;
  assign bus.FrameDone = frame_done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed and randomized bench for mux_scan_ctrl; expected traces come from
// a frame-arithmetic model of the scan schedule.
module tb_mux_scan_ctrl;

  localparam int unsigned DWELL_W = 16;
  localparam int unsigned BLANK_P = 4;

  logic Clk;
  logic Reset;
  int   checks;
  int   failures;

  mux_scan_ctrl_if #(.DWELL_W(DWELL_W)) bus ();

  mux_scan_ctrl #(.DWELL_W(DWELL_W), .BLANK(BLANK_P)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs t cycles after the scan started: digit k of the unmasked
  // list is on for max(dwell,1) cycles, then off for BLANK cycles, repeating.
  function automatic void model(input int dwell, input logic [3:0] mask, input int t,
                                output logic [1:0] s, output logic [3:0] dig,
                                output logic blank, output logic fd);
    int pos[4];
    int n;
    int eff;
    int per;
    int k;
    int ph;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      pos[i] = 0;
      if (!mask[i]) begin
        pos[n] = i;
        n++;
      end
    end
    eff   = (dwell == 0) ? 1 : dwell;
    per   = eff + int'(BLANK_P);
    k     = (t / per) % n;
    ph    = t % per;
    s     = 2'(pos[k]);
    blank = (ph >= eff);
    dig   = blank ? 4'b0000 : (4'b0001 << s);
    fd    = (t > 0) && (ph == 0) && (k == 0);
  endfunction

  // Compare ncyc consecutive cycles against the model; returns last S and FrameDone count.
  task automatic follow(input string tag, input int dwell, input logic [3:0] mask,
                        input int ncyc, output logic [1:0] last_s, output int fd_cnt);
    logic [1:0] es;
    logic [3:0] ed;
    logic       eb;
    logic       ef;
    fd_cnt = 0;
    last_s = 2'b00;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge Clk);
      model(dwell, mask, t, es, ed, eb, ef);
      chk({tag, "_S"},     16'(bus.S),         16'(es));
      chk({tag, "_Dig"},   16'(bus.Dig),       16'(ed));
      chk({tag, "_Blank"}, 16'(bus.Blank),     16'(eb));
      chk({tag, "_FD"},    16'(bus.FrameDone), 16'(ef));
      if (bus.FrameDone === 1'b1) fd_cnt++;
      last_s = es;
    end
  endtask

  task automatic chk_idle(input string tag, input logic [1:0] exp_s);
    chk({tag, "_S"},     16'(bus.S),         16'(exp_s));
    chk({tag, "_Dig"},   16'(bus.Dig),       16'h0);
    chk({tag, "_Blank"}, 16'(bus.Blank),     16'h1);
    chk({tag, "_FD"},    16'(bus.FrameDone), 16'h0);
  endtask

  initial begin
    logic [1:0] ls;
    int         fdc;
    int         dw;
    logic [3:0] mk;

    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    bus.En    = 1'b0;
    bus.Sync  = 1'b0;
    bus.Dwell = '0;
    bus.Mask  = 4'b0000;

    // Reset values
    #3;
    chk_idle("reset", 2'b00);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk_idle("idle_en0", 2'b00);

    // Full scan, Dwell=3, all digits: one wrap in 56 cycles (at t=28)
    bus.Dwell = 16'd3;
    bus.En    = 1'b1;
    follow("basic", 3, 4'b0000, 56, ls, fdc);
    chk("basic_fd_count", 16'(fdc), 16'd1);

    // Drop En and restart so each scenario starts from IDLE
    bus.En = 1'b0;
    @(negedge Clk);
    chk_idle("drop_basic", ls);

    // Dwell=0 behaves as 1: period 5
    bus.Dwell = 16'd0;
    bus.En    = 1'b1;
    follow("dwell0", 0, 4'b0000, 22, ls, fdc);
    chk("dwell0_fd_count", 16'(fdc), 16'd1);
    bus.En = 1'b0;
    @(negedge Clk);
    chk_idle("drop_dwell0", ls);

    // Mask 1010: alternate 0,2
    bus.Dwell = 16'd3;
    bus.Mask  = 4'b1010;
    bus.En    = 1'b1;
    follow("mask1010", 3, 4'b1010, 30, ls, fdc);
    chk("mask1010_fd_count", 16'(fdc), 16'd2);
    bus.En = 1'b0;
    @(negedge Clk);
    chk_idle("drop_mask1010", ls);

    // Mask 1110: single digit, wrap every 7 cycles
    bus.Mask = 4'b1110;
    bus.En   = 1'b1;
    follow("mask1110", 3, 4'b1110, 29, ls, fdc);
    chk("mask1110_fd_count", 16'(fdc), 16'd4);
    bus.En = 1'b0;
    @(negedge Clk);
    chk_idle("drop_mask1110", ls);

    // Mask 1111 with En: stays idle
    bus.Mask = 4'b1111;
    bus.En   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk_idle("mask1111", ls);
    end
    bus.En = 1'b0;
    @(negedge Clk);

    // Mask goes all-ones mid-dwell: the digit finishes, then idle with no wrap pulse
    bus.Mask = 4'b0000;
    bus.En   = 1'b1;
    follow("midmask", 3, 4'b0000, 2, ls, fdc);
    bus.Mask = 4'b1111;
    @(negedge Clk);
    chk("midmask_dig_t2", 16'(bus.Dig), 16'h1);
    for (int t = 3; t < 7; t++) begin
      @(negedge Clk);
      chk("midmask_gap_blank", 16'(bus.Blank), 16'h1);
    end
    for (int t = 7; t < 12; t++) begin
      @(negedge Clk);
      chk_idle("midmask_idle", 2'b00);
    end
    bus.En   = 1'b0;
    bus.Mask = 4'b0000;
    @(negedge Clk);

    // Sync while showing digit 2: gap, then digit 0 without FrameDone
    bus.En = 1'b1;
    follow("presync", 3, 4'b0000, 15, ls, fdc);
    chk("presync_on_digit2", 16'(bus.Dig), 16'h4);
    bus.Sync = 1'b1;
    @(negedge Clk);
    bus.Sync = 1'b0;
    chk_idle("sync_gap0", 2'd2);
    for (int i = 1; i < int'(BLANK_P); i++) begin
      @(negedge Clk);
      chk_idle("sync_gap", 2'd2);
    end
    follow("postsync", 3, 4'b0000, 30, ls, fdc);

    // En dropped mid-dwell on digit 1, S held, then restart at digit 0
    bus.En = 1'b0;
    @(negedge Clk);
    bus.En = 1'b1;
    follow("preen", 3, 4'b0000, 9, ls, fdc);
    chk("preen_on_digit1", 16'(bus.Dig), 16'h2);
    bus.En = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk_idle("endrop", 2'd1);
    end
    bus.En = 1'b1;
    follow("reen", 3, 4'b0000, 30, ls, fdc);

    // Asynchronous reset mid-SHOW
    chk("prerst_showing", 16'(bus.Blank), 16'h0);
    #1 Reset = 1'b1;
    #1;
    chk_idle("async_rst", 2'b00);
    @(negedge Clk);
    chk_idle("async_rst_hold", 2'b00);
    Reset = 1'b0;
    follow("postrst", 3, 4'b0000, 30, ls, fdc);
    bus.En = 1'b0;
    @(negedge Clk);
    chk_idle("drop_postrst", ls);

    // Randomized configurations
    for (int r = 0; r < 6; r++) begin
      dw = int'($urandom_range(0, 5));
      mk = 4'($urandom_range(0, 14));
      bus.Dwell = 16'(dw);
      bus.Mask  = mk;
      bus.En    = 1'b1;
      follow("rand", dw, mk, 2 * 4 * ((dw == 0 ? 1 : dw) + int'(BLANK_P)) + 3, ls, fdc);
      bus.En = 1'b0;
      @(negedge Clk);
      chk_idle("rand_drop", ls);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Scan sequencer that drives the 2-bit select of the dual 4-to-1 digit multiplexer and the matching digit enables of a 4-digit multiplexed display. It sits directly upstream of the mux. It steps the select through the enabled digit positions with a programmable dwell time and a fixed blanking gap between digits to prevent ghosting. It emits a one-cycle frame marker each time the scan wraps.

## Interface

Parameters:
- DWELL_W, 16, width of the dwell-count input.
- BLANK, 4, gap length in clock cycles between digits; legal range 1..255.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- En  in  1  scan enable; level-sensitive.
- Sync  in  1  restart the frame at the first unmasked digit; single-cycle pulse.
- Dwell  in  DWELL_W  on-time per digit in cycles; 0 is treated as 1.
- Mask  in  4  bit i = 1 skips digit position i.
- S  out  2  select to the downstream mux (00=A, 01=B, 10=C, 11=D).
- Dig  out  4  one-hot active-high digit enable, equal to the decode of S while showing.
- Blank  out  1  high when no digit is driven.
- FrameDone  out  1  one-cycle pulse on scan wrap.

## Operation

- Reset is one clock domain, asynchronous and active-high. While Reset=1: state IDLE, S=00, Dig=0000, Blank=1, FrameDone=0, dwell and gap counters 0.
- All outputs are registered. No combinational path runs from any input to any output.
- "Next unmasked index after i": search i+1, i+2, … modulo 4, including i itself last. "First unmasked" is the search starting at 0.
- IDLE:
  - Dig=0000 and Blank=1.
  - If En=1 and Mask≠1111: go to SHOW with S = first unmasked index.
  - Otherwise remain in IDLE.
- SHOW:
  - Dig = onehot(S), Blank=0.
  - Dwell is sampled on entry; the effective value is max(Dwell,1).
  - Stay in SHOW exactly that many cycles, then go to GAP.
- GAP:
  - Dig=0000, Blank=1, and S holds its value.
  - Stay exactly BLANK cycles.
  - On the last GAP cycle, S loads the next unmasked index and the state returns to SHOW.
  - If the new index is ≤ the old index (wrap, including the single-digit case), FrameDone=1 for that one cycle.
- Mask:
  - Mask is sampled only when choosing the next index.
  - A digit masked mid-dwell completes its dwell.
  - If Mask=1111 at selection time, go to IDLE; FrameDone is not asserted.
- En:
  - En=0 in any state forces IDLE on the next edge: Dig=0000, Blank=1.
  - S keeps its last value.
  - The counters clear.
- Sync=1 (when En=1):
  - On the next edge, enter GAP with a freshly cleared gap counter.
  - The next S is the first unmasked index.
  - No FrameDone is generated.
  - Sync outranks the normal dwell/gap transitions in the same cycle; En=0 outranks Sync.
- Counters saturate-free: the dwell counter is DWELL_W bits, the gap counter is 8 bits. Both reset to 0 on every state entry.

## Timing

- En rising (IDLE, Mask=0000) at edge k: Dig=0001 and Blank=0 from edge k+1.
- Digit period = max(Dwell,1) + BLANK cycles.
- Full frame with n unmasked digits = n × (max(Dwell,1) + BLANK) cycles.
- FrameDone rises on the same edge on which S wraps, and is high exactly one cycle.
- Dig is never non-zero on two different positions in consecutive cycles: at least BLANK cycles of 0000 separate any two positions.
- Reset asserted mid-SHOW: outputs go to reset values immediately (asynchronously), without waiting for Clk.

## Test plan

- Reset then En=1, Dwell=3, BLANK=4, Mask=0000 → S sequence 0,1,2,3,0 with Dig on 3 cycles and off 4 cycles each; FrameDone exactly once per 28 cycles, coincident with S 3→0.
- Dwell=0 → each digit shown exactly 1 cycle; period 5 cycles.
- Mask=1010 → S alternates 0,2; Mask=1110 → S stays 0 and FrameDone pulses every 7 cycles with Dwell=3; Mask=1111 → IDLE, Dig=0000, Blank=1.
- Sync pulse while showing digit 2 → next cycle Blank=1, after 4 gap cycles S=0 and Dig=0001, no FrameDone.
- En dropped mid-dwell on digit 1 → next edge Dig=0000, Blank=1, S=01 held; re-enable restarts at first unmasked digit.
- Reset asserted asynchronously mid-SHOW → outputs immediately S=00, Dig=0000, Blank=1, FrameDone=0; scan resumes from digit 0 after release.
